hash_table_ctrl: RTL and testbench
==================================

HASH_TABLE_CTRL -- requirements
Module: hash_table_ctrl

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 32, key width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, payload width in bits.
REQ-003 SHALL have parameter HASH_ADR_WIDTH, default 5, table address width; the table holds 2**HASH_ADR_WIDTH slots.
REQ-004 SHALL have parameter Q_MATRIX, default all rows 1, the H3 matrix, passed unchanged to the hash.
REQ-005 SHALL have one clock and a synchronous, active-low reset, with ports as follows.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- op_valid  input  1  request valid.
- op_ready  output  1  controller can accept a request.
- op_code  input  2  0=LOOKUP, 1=INSERT, 2=DELETE, 3=reserved.
- key_in  input  KEY_WIDTH  request key.
- data_in  input  DATA_WIDTH  insert payload.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- res_status  output  2  0=OK, 1=NOT_FOUND, 2=COLLISION, 3=BAD_OP.
- res_data  output  DATA_WIDTH  lookup payload.
- mem_adr  output  HASH_ADR_WIDTH  table address.
- mem_wr_en  output  1  table write strobe.
- mem_wr_data  output  1+KEY_WIDTH+DATA_WIDTH  {valid, key, data}.
- mem_rd_data  input  1+KEY_WIDTH+DATA_WIDTH  read data, 1-cycle latency after mem_adr.
- stat_lookups, stat_hits, stat_collisions  output  16 each  statistics counters.

Function
REQ-006 SHALL implement a direct-mapped table with one slot per H3 hash of the key, accessed through the single-port memory interface.
REQ-007 SHALL use FSM states IDLE, READ, CMP, WRITE, RESP.
- IDLE -> READ on op_valid&&op_ready.
- READ -> CMP.
- CMP -> WRITE when a write is needed, else CMP -> RESP.
- WRITE -> RESP.
- RESP -> IDLE on res_ready.
REQ-008 SHALL assert op_ready only in IDLE, and SHALL register op_code, key_in and data_in on acceptance.
REQ-009 SHALL drive mem_adr with the hash of the registered key during READ and WRITE, and SHALL sample mem_rd_data in CMP.
REQ-010 SHALL, for LOOKUP, respond with OK and the slot data if the slot is valid and its key matches, else NOT_FOUND with res_data=0.
REQ-011 SHALL, for INSERT, write {1,key,data} if the slot is empty or the keys match (status OK), else skip the write and respond COLLISION.
REQ-012 SHALL, for DELETE, write {0,0,0} on a key match (status OK), else skip the write and respond NOT_FOUND.
REQ-013 SHALL respond to op_code 3 with BAD_OP, skipping READ/CMP and never touching memory.
REQ-014 SHALL assert mem_wr_en only in WRITE, for exactly one cycle.
REQ-015 SHALL have a latency from acceptance edge to res_valid of 3 cycles without a write and 4 cycles with a write.
REQ-016 SHALL hold res_valid, res_status and res_data stable while res_ready is low.
REQ-017 SHALL ignore a new request while busy; it is not accepted until op_ready is high.

Reset
REQ-018 SHALL, when rst_n is low, force state IDLE, res_valid=0, mem_wr_en=0, res_status=0, res_data=0, mem_adr=0 and all counters 0.
REQ-019 SHALL abort any in-flight operation on reset without a memory write, even if reset is asserted during WRITE; the cycle with rst_n low has mem_wr_en=0.
REQ-020 SHALL NOT clear table contents on reset; clearing is the memory owner's job.

Configuration
REQ-021 SHALL, with HASH_TABLE_CTRL_STATS_EN defined, make the counters behave as follows, each incrementing on the RESP->IDLE handshake and saturating at 0xFFFF.
- stat_lookups counts LOOKUP ops.
- stat_hits counts LOOKUP ops with status OK.
- stat_collisions counts INSERT ops with status COLLISION.
REQ-022 SHALL, without HASH_TABLE_CTRL_STATS_EN, keep the counter ports present and tied to 0, with no counter registers synthesized.

Structure
REQ-023 SHALL take the op_t and status_t enums and the entry struct {valid, key, data} from shared package hash_table_pkg; widths are parameterized by the struct users.
REQ-024 SHALL compute the hash with one h3_hash_function instance, the only sub-module, fed by the registered key.

Verification
REQ-025 SHALL cover: INSERT key 0x11, data 0xAA into an empty table -> mem_wr_en pulses once in cycle 3 after accept, res_status=OK in cycle 4.
REQ-026 SHALL cover: LOOKUP 0x11 after the REQ-025 insert -> OK with res_data 0xAA at cycle 3; LOOKUP of an absent key -> NOT_FOUND with res_data 0.
REQ-027 SHALL cover: INSERT of a second key with the same hash as 0x11 -> COLLISION, no write, stat_collisions=1 with the macro defined.
REQ-028 SHALL cover: DELETE 0x11 then LOOKUP 0x11 -> OK then NOT_FOUND; DELETE again -> NOT_FOUND with no write.
REQ-029 SHALL cover: res_ready held low for 5 cycles -> outputs stable and op_ready=0 throughout; an op_valid pulse during that time is not accepted.
REQ-030 SHALL cover: rst_n low in the WRITE cycle -> mem_wr_en=0, next cycle IDLE with op_ready=1 and res_valid=0.

Source files
------------

// File: rtl/hash_table_pkg.sv
// Shared types for the hash table controller: request opcodes, response
// status codes and the saturating statistics helper.
package hash_table_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_RSVD   = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_NOT_FOUND = 2'd1,
        ST_COLLISION = 2'd2,
        ST_BAD_OP    = 2'd3
    } status_t;

    localparam int STAT_WIDTH = 16;
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (v == STAT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/h3_hash_function.sv
// H3 universal hash: each set key bit XORs its row of Q_MATRIX into the
// result. Row i occupies bits [i*HASH_ADR_WIDTH +: HASH_ADR_WIDTH].
module h3_hash_function #(
    parameter int KEY_WIDTH      = 32,
    parameter int HASH_ADR_WIDTH = 5,
    parameter logic [KEY_WIDTH*HASH_ADR_WIDTH-1:0] Q_MATRIX =
        {KEY_WIDTH{HASH_ADR_WIDTH'(1)}}
) (
    input  logic [KEY_WIDTH-1:0]      key,
    output logic [HASH_ADR_WIDTH-1:0] hash
);

    // Fold the matrix rows selected by the key bits.
    always_comb begin
        // NOTE: blocking '=' is right here: the XOR accumulates within one
        // evaluation, and the '0 default keeps this purely combinational.
        hash = '0;
        for (int i = 0; i < KEY_WIDTH; i++) begin
            if (key[i]) begin
                hash = hash ^ Q_MATRIX[i*HASH_ADR_WIDTH +: HASH_ADR_WIDTH];
            end
        end
    end

endmodule

// File: rtl/hash_table_ctrl.sv
// Direct-mapped hash table controller in front of a single-port memory with
// one cycle of read latency. One request at a time:
// IDLE -> READ -> CMP -> (WRITE) -> RESP.
// Optional macro HASH_TABLE_CTRL_STATS_EN enables the saturating statistics
// counters; without it the stat ports are constant zero.
module hash_table_ctrl
    import hash_table_pkg::*;
#(
    parameter int KEY_WIDTH      = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int HASH_ADR_WIDTH = 5,
    parameter logic [KEY_WIDTH*HASH_ADR_WIDTH-1:0] Q_MATRIX =
        {KEY_WIDTH{HASH_ADR_WIDTH'(1)}}
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               op_valid,
    output logic                               op_ready,
    input  logic [1:0]                         op_code,
    input  logic [KEY_WIDTH-1:0]               key_in,
    input  logic [DATA_WIDTH-1:0]              data_in,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [1:0]                         res_status,
    output logic [DATA_WIDTH-1:0]              res_data,
    output logic [HASH_ADR_WIDTH-1:0]          mem_adr,
    output logic                               mem_wr_en,
    output logic [KEY_WIDTH+DATA_WIDTH:0]      mem_wr_data,
    input  logic [KEY_WIDTH+DATA_WIDTH:0]      mem_rd_data,
    output logic [STAT_WIDTH-1:0]              stat_lookups,
    output logic [STAT_WIDTH-1:0]              stat_hits,
    output logic [STAT_WIDTH-1:0]              stat_collisions
);

    // Slot layout {valid, key, data}; declared here because its field
    // widths come from this module's parameters.
    typedef struct packed {
        logic                  valid;
        logic [KEY_WIDTH-1:0]  key;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] CMP   = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    logic [2:0]            state;
    op_t                   op_q;
    logic [KEY_WIDTH-1:0]  key_q;
    logic [DATA_WIDTH-1:0] data_q;
    entry_t                wr_entry;
    status_t               status_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  valid_q;

    logic [HASH_ADR_WIDTH-1:0] slot;
    entry_t                rd_entry;
    logic                  key_match;
    logic                  cmp_write;
    status_t               cmp_status;
    logic [DATA_WIDTH-1:0] cmp_data;
    entry_t                cmp_entry;

    h3_hash_function #(
        .KEY_WIDTH      (KEY_WIDTH),
        .HASH_ADR_WIDTH (HASH_ADR_WIDTH),
        .Q_MATRIX       (Q_MATRIX)
    ) u_hash (
        .key  (key_q),
        .hash (slot)
    );

    // Gating with rst_n keeps a reset cycle from ever writing the table,
    // even when reset lands on the WRITE cycle.
    assign op_ready    = rst_n && (state == IDLE);
    assign mem_wr_en   = rst_n && (state == WRITE);
    assign mem_adr     = (rst_n && (state == READ || state == WRITE)) ? slot : '0;
    assign mem_wr_data = wr_entry;
    assign res_valid   = valid_q;
    assign res_status  = status_q;
    assign res_data    = data_out_q;
    assign rd_entry    = mem_rd_data;

    // Decide the outcome from the slot returned during CMP.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        key_match  = rd_entry.valid && (rd_entry.key == key_q);
        cmp_write  = 1'b0;
        cmp_status = ST_NOT_FOUND;
        cmp_data   = '0;
        cmp_entry  = '0;
        case (op_q)
            OP_LOOKUP: begin
                if (key_match) begin
                    cmp_status = ST_OK;
                    cmp_data   = rd_entry.data;
                end
            end
            OP_INSERT: begin
                if (!rd_entry.valid || key_match) begin
                    cmp_write       = 1'b1;
                    cmp_status      = ST_OK;
                    cmp_entry.valid = 1'b1;
                    cmp_entry.key   = key_q;
                    cmp_entry.data  = data_q;
                end else begin
                    cmp_status = ST_COLLISION;
                end
            end
            OP_DELETE: begin
                if (key_match) begin
                    cmp_write  = 1'b1;
                    cmp_status = ST_OK;
                end
            end
            default: cmp_status = ST_BAD_OP;
        endcase
    end

    // Request sequencing, request capture and the held response registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking '<=' so every register sees pre-edge values.
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= OP_LOOKUP;
            key_q      <= '0;
            data_q     <= '0;
            wr_entry   <= '0;
            valid_q    <= 1'b0;
            status_q   <= ST_OK;
            data_out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid && op_ready) begin
                        op_q   <= op_t'(op_code);
                        key_q  <= key_in;
                        data_q <= data_in;
                        if (op_t'(op_code) == OP_RSVD) begin
                            state      <= RESP;
                            valid_q    <= 1'b1;
                            status_q   <= ST_BAD_OP;
                            data_out_q <= '0;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: state <= CMP;
                CMP: begin
                    status_q   <= cmp_status;
                    data_out_q <= cmp_data;
                    wr_entry   <= cmp_entry;
                    if (cmp_write) begin
                        state <= WRITE;
                    end else begin
                        state   <= RESP;
                        valid_q <= 1'b1;
                    end
                end
                WRITE: begin
                    state   <= RESP;
                    valid_q <= 1'b1;
                end
                RESP: begin
                    if (res_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the table itself lives outside this block and is deliberately
    // not cleared on reset; the memory owner decides when to wipe it.

`ifdef HASH_TABLE_CTRL_STATS_EN
    logic [STAT_WIDTH-1:0] lookups_q;
    logic [STAT_WIDTH-1:0] hits_q;
    logic [STAT_WIDTH-1:0] collisions_q;

    // Count completed operations on the response handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lookups_q    <= '0;
            hits_q       <= '0;
            collisions_q <= '0;
        end else if (state == RESP && res_ready) begin
            if (op_q == OP_LOOKUP) begin
                lookups_q <= sat_inc(lookups_q);
                if (status_q == ST_OK) begin
                    hits_q <= sat_inc(hits_q);
                end
            end
            if (op_q == OP_INSERT && status_q == ST_COLLISION) begin
                collisions_q <= sat_inc(collisions_q);
            end
        end
    end

    assign stat_lookups    = lookups_q;
    assign stat_hits       = hits_q;
    assign stat_collisions = collisions_q;
`else
    assign stat_lookups    = '0;
    assign stat_hits       = '0;
    assign stat_collisions = '0;
`endif

endmodule

// File: tb/tb_hash_table_ctrl.sv
// Self-checking bench for hash_table_ctrl: directed scenarios with literal
// expectations, then random traffic against a slot-level reference model.
// Inputs change 2 time units after a rising edge; outputs are read on the
// falling edge.
module tb_hash_table_ctrl;

    localparam int KW    = 32;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int SLOTS = 1 << AW;
    localparam int EW    = 1 + KW + DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          op_valid;
    logic          op_ready;
    logic [1:0]    op_code;
    logic [KW-1:0] key_in;
    logic [DW-1:0] data_in;
    logic          res_valid;
    logic          res_ready;
    logic [1:0]    res_status;
    logic [DW-1:0] res_data;
    logic [AW-1:0] mem_adr;
    logic          mem_wr_en;
    logic [EW-1:0] mem_wr_data;
    logic [EW-1:0] mem_rd_data;
    logic [15:0]   stat_lookups;
    logic [15:0]   stat_hits;
    logic [15:0]   stat_collisions;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hash_table_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .op_code         (op_code),
        .key_in          (key_in),
        .data_in         (data_in),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_status      (res_status),
        .res_data        (res_data),
        .mem_adr         (mem_adr),
        .mem_wr_en       (mem_wr_en),
        .mem_wr_data     (mem_wr_data),
        .mem_rd_data     (mem_rd_data),
        .stat_lookups    (stat_lookups),
        .stat_hits       (stat_hits),
        .stat_collisions (stat_collisions)
    );

    // Table storage owned by the bench: one-cycle read latency.
    logic [EW-1:0] mem [SLOTS];
    initial for (int i = 0; i < SLOTS; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_adr] <= mem_wr_data;
        mem_rd_data <= mem[mem_adr];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // With every Q row equal to 1 each set key bit flips only bit 0,
    // so the slot is simply the key's parity.
    function automatic logic [AW-1:0] model_slot(input logic [KW-1:0] k);
        return {{(AW-1){1'b0}}, ^k};
    endfunction

    bit            m_valid [SLOTS];
    logic [KW-1:0] m_key   [SLOTS];
    logic [DW-1:0] m_data  [SLOTS];
    int            m_lookups, m_hits, m_colls;

    bit            busy;
    int            cyc, exp_lat;
    bit            exp_wr;
    logic [1:0]    exp_op, exp_st;
    logic [DW-1:0] exp_rd;
    logic [EW-1:0] exp_wdata;
    logic [AW-1:0] exp_slot;

    function automatic int sat16(input int v);
        return (v >= 16'hFFFF) ? 16'hFFFF : v + 1;
    endfunction

    // Compare process: checks every output each cycle against the model.
    initial begin
        busy = 1'b0;
        m_lookups = 0; m_hits = 0; m_colls = 0;
        for (int i = 0; i < SLOTS; i++) begin
            m_valid[i] = 1'b0; m_key[i] = '0; m_data[i] = '0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("wr_en_in_reset", mem_wr_en, 1'b0);
                busy = 1'b0;
                m_lookups = 0; m_hits = 0; m_colls = 0;
            end else begin
`ifdef HASH_TABLE_CTRL_STATS_EN
                check("stat_lookups", stat_lookups, m_lookups);
                check("stat_hits", stat_hits, m_hits);
                check("stat_collisions", stat_collisions, m_colls);
`else
                check("stat_lookups_off", stat_lookups, 0);
                check("stat_hits_off", stat_hits, 0);
                check("stat_collisions_off", stat_collisions, 0);
`endif
                if (busy) begin
                    cyc++;
                    check("busy_op_ready", op_ready, 1'b0);
                    check("mem_wr_en", mem_wr_en, exp_wr && cyc == 3);
                    if (exp_wr && cyc == 3) begin
                        check("write_adr", mem_adr, exp_slot);
                        check("write_data", mem_wr_data, exp_wdata);
                    end
                    if (cyc == 1 && exp_op != 2'd3) check("read_adr", mem_adr, exp_slot);
                    check("res_valid", res_valid, cyc >= exp_lat);
                    if (cyc >= exp_lat) begin
                        check("res_status", res_status, exp_st);
                        check("res_data", res_data, exp_rd);
                    end
                    if (res_valid && res_ready) begin
                        if (exp_wr) begin
                            m_valid[exp_slot] = (exp_op == 2'd1);
                            m_key[exp_slot]   = (exp_op == 2'd1) ? key_of(exp_wdata) : '0;
                            m_data[exp_slot]  = (exp_op == 2'd1) ? exp_wdata[DW-1:0] : '0;
                        end
                        if (exp_op == 2'd0) begin
                            m_lookups = sat16(m_lookups);
                            if (exp_st == 2'd0) m_hits = sat16(m_hits);
                        end
                        if (exp_op == 2'd1 && exp_st == 2'd2) m_colls = sat16(m_colls);
                        busy = 1'b0;
                    end else if (cyc > 60) begin
                        check("response_timeout", res_valid && res_ready, 1'b1);
                        busy = 1'b0;
                    end
                end else begin
                    check("idle_op_ready", op_ready, 1'b1);
                    check("idle_res_valid", res_valid, 1'b0);
                    check("idle_mem_wr_en", mem_wr_en, 1'b0);
                    if (op_valid && op_ready) begin
                        predict(op_code, key_in, data_in);
                        busy = 1'b1;
                        cyc  = 0;
                    end
                end
            end
        end
    end

    function automatic logic [KW-1:0] key_of(input logic [EW-1:0] e);
        return e[DW +: KW];
    endfunction

    // Expected outcome of one request from the table rules.
    task automatic predict(input logic [1:0] op, input logic [KW-1:0] k, input logic [DW-1:0] d);
        logic [AW-1:0] s;
        bit            hit;
        s   = model_slot(k);
        hit = m_valid[s] && (m_key[s] == k);
        exp_op = op; exp_slot = s; exp_wr = 1'b0; exp_rd = '0; exp_wdata = '0;
        case (op)
            2'd0: begin exp_st = hit ? 2'd0 : 2'd1; exp_rd = hit ? m_data[s] : '0; end
            2'd1: begin
                if (!m_valid[s] || hit) begin
                    exp_st = 2'd0; exp_wr = 1'b1; exp_wdata = {1'b1, k, d};
                end else exp_st = 2'd2;
            end
            2'd2: begin exp_st = hit ? 2'd0 : 2'd1; exp_wr = hit; end
            default: exp_st = 2'd3;
        endcase
        exp_lat = (op == 2'd3) ? 1 : (exp_wr ? 4 : 3);
    endtask

    // ---------------- driver ----------------
    task automatic do_op(input logic [1:0] op, input logic [KW-1:0] k, input logic [DW-1:0] d,
                         input int hold, input bit pulse,
                         output logic [1:0] st, output logic [DW-1:0] rd,
                         output int lat, output int nwr, output int wr_cyc);
        int t;
        @(posedge clk); #2;
        t = 0;
        while (!op_ready && t < 50) begin @(posedge clk); #2; t++; end
        if (!op_ready) check("op_ready_timeout", op_ready, 1'b1);
        op_valid = 1'b1; op_code = op; key_in = k; data_in = d;
        @(posedge clk); #2;
        op_valid = 1'b0; res_ready = 1'b0;
        lat = 0; nwr = 0; wr_cyc = 0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_wr_en) begin nwr++; wr_cyc = lat; end
        end while (!res_valid && lat < 20);
        if (!res_valid) begin
            check("res_valid_timeout", res_valid, 1'b1);
            lat = -1;
        end
        st = res_status; rd = res_data;
        @(posedge clk); #2;
        for (int h = 0; h < hold; h++) begin
            if (pulse && h == 0) begin
                op_valid = 1'b1; op_code = 2'd1; key_in = 32'h01; data_in = 32'h55;
            end else op_valid = 1'b0;
            @(negedge clk);
            if (pulse) begin
                check("hold_op_ready", op_ready, 1'b0);
                check("hold_status", res_status, st);
                check("hold_data", res_data, rd);
            end
            @(posedge clk); #2;
        end
        op_valid = 1'b0; res_ready = 1'b1;
        @(posedge clk); #2;
        res_ready = 1'b0;
    endtask

    logic [1:0]    st;
    logic [DW-1:0] rd;
    int            lat, nwr, wcy;
    logic [KW-1:0] key_pool [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
        op_code = '0; key_in = '0; data_in = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_op_ready", op_ready, 1'b1);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_status", res_status, 2'd0);
        check("rst_res_data", res_data, 0);
        check("rst_mem_adr", mem_adr, 0);
        check("rst_mem_wr_en", mem_wr_en, 1'b0);
        check("rst_stat_lookups", stat_lookups, 0);

        // Insert into an empty table: write in cycle 3, response in cycle 4.
        do_op(2'd1, 32'h11, 32'hAA, 0, 1'b0, st, rd, lat, nwr, wcy);
        check("ins_status", st, 2'd0);
        check("ins_latency", lat, 4);
        check("ins_write_count", nwr, 1);
        check("ins_write_cycle", wcy, 3);

        do_op(2'd0, 32'h11, 32'h0, 0, 1'b0, st, rd, lat, nwr, wcy);
        check("lkp_hit_status", st, 2'd0);
        check("lkp_hit_data", rd, 32'hAA);
        check("lkp_hit_latency", lat, 3);

        do_op(2'd0, 32'h05, 32'h0, 1, 1'b0, st, rd, lat, nwr, wcy);
        check("lkp_miss_status", st, 2'd1);
        check("lkp_miss_data", rd, 0);

        // 0x22 shares slot 0 with 0x11.
        do_op(2'd1, 32'h22, 32'hBB, 0, 1'b0, st, rd, lat, nwr, wcy);
        check("coll_status", st, 2'd2);
        check("coll_write_count", nwr, 0);
        check("coll_latency", lat, 3);
`ifdef HASH_TABLE_CTRL_STATS_EN
        check("coll_stat", stat_collisions, 1);
`else
        check("coll_stat_off", stat_collisions, 0);
`endif

        // Consumer stalls 5 cycles; a request pulse meanwhile must be dropped.
        do_op(2'd0, 32'h11, 32'h0, 5, 1'b1, st, rd, lat, nwr, wcy);
        check("stall_status", st, 2'd0);
        check("stall_data", rd, 32'hAA);
        do_op(2'd0, 32'h01, 32'h0, 0, 1'b0, st, rd, lat, nwr, wcy);
        check("dropped_req_absent", st, 2'd1);

        do_op(2'd2, 32'h11, 32'h0, 0, 1'b0, st, rd, lat, nwr, wcy);
        check("del_status", st, 2'd0);
        check("del_write_count", nwr, 1);
        do_op(2'd0, 32'h11, 32'h0, 0, 1'b0, st, rd, lat, nwr, wcy);
        check("del_then_lkp", st, 2'd1);
        do_op(2'd2, 32'h11, 32'h0, 0, 1'b0, st, rd, lat, nwr, wcy);
        check("del_again_status", st, 2'd1);
        check("del_again_writes", nwr, 0);

        do_op(2'd3, 32'h11, 32'h0, 0, 1'b0, st, rd, lat, nwr, wcy);
        check("bad_op_status", st, 2'd3);
        check("bad_op_latency", lat, 1);
        check("bad_op_writes", nwr, 0);

        // Reset lands on the WRITE cycle of an insert into empty slot 1.
        @(posedge clk); #2;
        op_valid = 1'b1; op_code = 2'd1; key_in = 32'h07; data_in = 32'h77;
        @(posedge clk); #2 op_valid = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk);
        check("abort_wr_en", mem_wr_en, 1'b0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        check("abort_op_ready", op_ready, 1'b1);
        check("abort_res_valid", res_valid, 1'b0);
        do_op(2'd0, 32'h07, 32'h0, 0, 1'b0, st, rd, lat, nwr, wcy);
        check("abort_no_write", st, 2'd1);

        // Random traffic over a small key pool spanning both used slots.
        key_pool = '{32'h11, 32'h22, 32'h01, 32'h07, 32'h03, 32'h30, 32'hFF, 32'h100};
        for (int n = 0; n < 200; n++) begin
            int r;
            logic [1:0] op;
            r  = $urandom_range(0, 9);
            op = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            do_op(op, key_pool[$urandom_range(0, 7)], $urandom, $urandom_range(0, 3),
                  1'b0, st, rd, lat, nwr, wcy);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
